// File: rtl/servo_seq_pkg.sv
// servo_seq_pkg: shared constants and FSM encoding for the
// ADC -> IPD sample sequencer.
package servo_seq_pkg;

  localparam int FRAME_BITS       = 16;
  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_SAMPLE_TICKS = 10000;
  localparam int DEF_DATA_BITS    = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_UPDATE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: cs_1/sclk_1 generator and 16-bit MSB-first
// shift register for one ADC frame per start pulse.
module adc_spi_rx
  import servo_seq_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic                  start,
  input  logic                  DataIn,
  output logic                  cs_1,
  output logic                  sclk_1,
  output logic                  done,
  output logic [FRAME_BITS-1:0] frame
);

  logic       active;
  logic [7:0] hc;
  logic [4:0] ph;
  logic       half_end;

  assign half_end = (hc == 8'(CLK_DIV - 1));

  // Half-period divider; even phases drop sclk, odd phases raise and sample.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      active <= 1'b0;
      cs_1   <= 1'b1;
      sclk_1 <= 1'b1;
      done   <= 1'b0;
      hc     <= '0;
      ph     <= '0;
      frame  <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active <= 1'b1;
          cs_1   <= 1'b0;
          hc     <= '0;
          ph     <= '0;
        end
      end else if (half_end) begin
        hc     <= '0;
        ph     <= ph + 5'd1;
        sclk_1 <= ph[0];
        if (ph[0]) begin
          frame <= {frame[FRAME_BITS-2:0], DataIn};
        end
        if (ph == 5'd31) begin
          cs_1   <= 1'b1;
          active <= 1'b0;
          done   <= 1'b1;
        end
      end else begin
        hc <= hc + 8'd1;
      end
    end
  end

endmodule

// File: rtl/adc_ipd_sequencer.sv
// adc_ipd_sequencer: periodic ADC read, IPD handshake, output latch.
// Build option: ADC_OVERRUN_DETECT_EN enables the sticky overrun flag.
module adc_ipd_sequencer
  import servo_seq_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int SAMPLE_TICKS = DEF_SAMPLE_TICKS,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 Clk,
  input  logic                 Rest,
  input  logic                 enable,
  input  logic                 DataIn,
  output logic                 cs_1,
  output logic                 sclk_1,
  output logic [DATA_BITS-1:0] adc_data,
  output logic                 adc_valid,
  output logic                 ipd_start,
  input  logic                 ipd_done,
  input  logic [15:0]          ipd_result,
  output logic [15:0]          salida,
  output logic                 salida_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TW = $clog2(SAMPLE_TICKS);

  logic [TW-1:0]         tcnt;
  logic                  tick;
  seq_state_t            state;
  seq_state_t            state_nx;
  logic                  first_c;
  logic                  rx_start;
  logic                  rx_done;
  logic                  load_adc;
  logic                  load_out;
  logic [FRAME_BITS-1:0] frame;
  logic                  unused_frame;

  assign tick         = enable && (tcnt == TW'(SAMPLE_TICKS - 1));
  assign busy         = (state != ST_IDLE);
  assign unused_frame = ^frame;

  // Sample-period counter; parked at zero while disabled.
  always_ff @(posedge Clk) begin
    if (Rest || !enable) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Next state and one-cycle load decisions.
  always_comb begin
    state_nx = state;
    rx_start = 1'b0;
    load_adc = 1'b0;
    load_out = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tick) begin
          state_nx = ST_CONV;
          rx_start = 1'b1;
        end
      end
      ST_CONV: begin
        if (rx_done) begin
          state_nx = ST_COMPUTE;
          load_adc = 1'b1;
        end
      end
      ST_COMPUTE: begin
        if (ipd_done && !first_c) begin
          state_nx = ST_UPDATE;
          load_out = 1'b1;
        end
      end
      ST_UPDATE: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State register plus registered data/strobes aligned to the state entered.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state        <= ST_IDLE;
      first_c      <= 1'b0;
      adc_data     <= '0;
      adc_valid    <= 1'b0;
      ipd_start    <= 1'b0;
      salida       <= '0;
      salida_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      first_c      <= load_adc;
      adc_valid    <= load_adc;
      ipd_start    <= load_adc;
      salida_valid <= load_out;
      if (load_adc) begin
        adc_data <= frame[DATA_BITS-1:0];
      end
      if (load_out) begin
        salida <= ipd_result;
      end
    end
  end

`ifdef ADC_OVERRUN_DETECT_EN
  // Sticky: a tick arrived while a cycle was still in flight.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      overrun <= 1'b0;
    end else if (tick && busy) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

  adc_spi_rx #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .Clk   (Clk),
    .Rest  (Rest),
    .start (rx_start),
    .DataIn(DataIn),
    .cs_1  (cs_1),
    .sclk_1(sclk_1),
    .done  (rx_done),
    .frame (frame)
  );

endmodule

// File: tb/tb_adc_ipd_sequencer.sv
// tb_adc_ipd_sequencer: directed bench, CLK_DIV=2, SAMPLE_TICKS=200,
// IPD stand-in answering a fixed number of cycles after ipd_start.
module tb_adc_ipd_sequencer;

`ifdef ADC_OVERRUN_DETECT_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rest;
  logic        enable;
  logic        DataIn;
  logic        cs_1;
  logic        sclk_1;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        ipd_start;
  logic        ipd_done;
  logic [15:0] ipd_result;
  logic [15:0] salida;
  logic        salida_valid;
  logic        busy;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;
  int viol  = 0;

  always #5 Clk = ~Clk;

  adc_ipd_sequencer #(
    .CLK_DIV     (2),
    .SAMPLE_TICKS(200),
    .DATA_BITS   (12)
  ) dut (
    .Clk         (Clk),
    .Rest        (Rest),
    .enable      (enable),
    .DataIn      (DataIn),
    .cs_1        (cs_1),
    .sclk_1      (sclk_1),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .ipd_start   (ipd_start),
    .ipd_done    (ipd_done),
    .ipd_result  (ipd_result),
    .salida      (salida),
    .salida_valid(salida_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Serial pins must idle high whenever no cycle is running.
  always @(negedge Clk) begin
    if (Rest === 1'b0 && busy === 1'b0 &&
        (cs_1 !== 1'b1 || sclk_1 !== 1'b1)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_cycle(input string tag, input logic [15:0] fr,
                           input logic [11:0] exp_adc,
                           input logic [15:0] res, input int dly,
                           input bit early, input bit drop_en);
    int   n;
    int   low;
    int   rises;
    int   sv;
    logic prev;
    n = 0;
    DataIn = fr[15];
    while (cs_1 !== 1'b0 && n < 600) begin
      step();
      n++;
    end
    chk({tag, "_csfall"}, cs_1 === 1'b0, 1);
    if (drop_en) enable = 1'b0;
    low = 1;
    rises = 0;
    prev = sclk_1;
    while (cs_1 === 1'b0 && low < 200) begin
      if (rises < 16) DataIn = fr[15-rises];
      step();
      if (!prev && sclk_1) rises++;
      prev = sclk_1;
      if (cs_1 === 1'b0) low++;
    end
    chk({tag, "_cslow"}, low, 64);
    chk({tag, "_rises"}, rises, 16);
    n = 0;
    while (adc_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_adcv"}, adc_valid, 1);
    chk({tag, "_adc"}, adc_data, exp_adc);
    chk({tag, "_start"}, ipd_start, 1);
    ipd_result = res;
    if (early) begin
      ipd_done = 1'b1;
      step();
      ipd_done = 1'b0;
      sv = 0;
      for (int i = 0; i < 4; i++) begin
        if (salida_valid === 1'b1 || busy !== 1'b1) sv++;
        step();
      end
      chk({tag, "_early"}, sv, 0);
    end
    for (int i = 0; i < dly; i++) step();
    ipd_done = 1'b1;
    step();
    ipd_done = 1'b0;
    sv = 0;
    for (int i = 0; i < 4; i++) begin
      if (salida_valid === 1'b1) sv++;
      if (i == 0) chk({tag, "_sal"}, salida, res);
      step();
    end
    chk({tag, "_salv"}, sv, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int   n;
    int   rises;
    int   lows;
    logic prev;
    Rest = 1'b1;
    enable = 1'b0;
    DataIn = 1'b0;
    ipd_done = 1'b0;
    ipd_result = 16'h0000;
    step();
    step();
    step();
    chk("rst_cs", cs_1, 1);
    chk("rst_sclk", sclk_1, 1);
    chk("rst_adc", adc_data, 0);
    chk("rst_sal", salida, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_strb", {adc_valid, ipd_start, salida_valid}, 0);
    Rest = 1'b0;
    enable = 1'b1;

    run_cycle("f0abc", 16'h0ABC, 12'hABC, 16'h4B00, 5, 0, 0);
    run_cycle("fffff", 16'hFFFF, 12'hFFF, 16'h1234, 5, 0, 0);
    run_cycle("f0000", 16'h0000, 12'h000, 16'hFFFF, 5, 0, 0);
    chk("ovr_pre", overrun, 0);

    run_cycle("slow", 16'h0123, 12'h123, 16'h00AA, 300, 0, 0);
    chk("ovr_post", overrun, EXP_OVR);

    run_cycle("early", 16'h5A5A, 12'hA5A, 16'h0F0F, 5, 1, 0);

    n = 0;
    while (cs_1 !== 1'b0 && n < 600) begin
      step();
      n++;
    end
    chk("mr_csfall", cs_1 === 1'b0, 1);
    rises = 0;
    prev = sclk_1;
    n = 0;
    while (rises < 8 && n < 200) begin
      step();
      if (!prev && sclk_1) rises++;
      prev = sclk_1;
      n++;
    end
    chk("mr_rises", rises, 8);
    Rest = 1'b1;
    step();
    Rest = 1'b0;
    chk("mr_cs", cs_1, 1);
    chk("mr_sclk", sclk_1, 1);
    chk("mr_busy", busy, 0);
    chk("mr_strb", {adc_valid, ipd_start, salida_valid}, 0);
    chk("mr_ovr", overrun, 0);
    chk("mr_sal", salida, 0);

    run_cycle("after", 16'h0C3C, 12'hC3C, 16'h7777, 5, 0, 0);

    run_cycle("dropen", 16'h0321, 12'h321, 16'h1111, 5, 0, 1);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (cs_1 !== 1'b1) lows++;
    end
    chk("dropen_quiet", lows, 0);
    chk("idle_pins", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_ipd_sequencer.md
ADC_IPD_SEQUENCER -- requirements
Module: adc_ipd_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 4: Clk cycles per sclk_1 half-period; legal range 1..255.
REQ-002 Parameter SAMPLE_TICKS, default 10000: Clk cycles per sample period; SHALL be at least 32*CLK_DIV+8.
REQ-003 Parameter DATA_BITS, default 12: ADC result width, taken from the low bits of a 16-bit frame.
REQ-004 Clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 Rest  in  1  reset; synchronous, active-high.
REQ-006 enable  in  1  1 = sample ticks may start cycles.
REQ-007 DataIn  in  1  ADC serial data, MSB first.
REQ-008 cs_1  out  1  ADC chip select, active-low.
REQ-009 sclk_1  out  1  ADC serial clock; idles high.
REQ-010 adc_data  out  DATA_BITS  last captured ADC sample.
REQ-011 adc_valid  out  1  one-cycle strobe: adc_data updated.
REQ-012 ipd_start  out  1  one-cycle strobe: IPD controller computes.
REQ-013 ipd_done  in  1  IPD completion strobe.
REQ-014 ipd_result  in  16  IPD output word.
REQ-015 salida  out  16  latched control output.
REQ-016 salida_valid  out  1  one-cycle strobe: salida updated.
REQ-017 busy  out  1  high whenever the FSM is not IDLE.
REQ-018 overrun  out  1  sticky flag for a sample tick lost while busy.

Function
REQ-019 Tick counter SHALL count 0..SAMPLE_TICKS-1 while enable=1, raise tick at SAMPLE_TICKS-1, wrap, and hold at 0 while enable=0.
REQ-020 FSM states: IDLE, CONV, COMPUTE, UPDATE; IDLE->CONV on tick with enable=1; CONV->COMPUTE at end of frame; COMPUTE->UPDATE on ipd_done; UPDATE->IDLE unconditionally.
REQ-021 cs_1 SHALL fall on the cycle after the tick; sclk_1 falls at CLK_DIV*(2k+1) and rises at CLK_DIV*(2k+2) cycles after cs_1 falls, for k=0..15.
REQ-022 DataIn SHALL be sampled into a 16-bit shift register on each sclk_1 rising edge, MSB first.
REQ-023 cs_1 SHALL rise on the 16th sclk_1 rising edge, giving exactly 32*CLK_DIV cycles low.
REQ-024 On the first COMPUTE cycle, adc_data <= frame[DATA_BITS-1:0], and adc_valid and ipd_start pulse together; frame[15:DATA_BITS] SHALL be discarded.
REQ-025 ipd_done SHALL be ignored in the first COMPUTE cycle and accepted from the next cycle onward.
REQ-026 On accepted ipd_done, salida <= ipd_result in the UPDATE cycle, and salida_valid pulses in that cycle.
REQ-027 A tick arriving outside IDLE SHALL be dropped; it does not queue a cycle.
REQ-028 enable falling mid-cycle SHALL let the current cycle finish through UPDATE and start no new one.
REQ-029 While Rest=0, cs_1 and sclk_1 SHALL remain high throughout IDLE, COMPUTE and UPDATE.

Reset
REQ-030 Rest=1 at a Clk edge SHALL force IDLE from any state, including mid-frame, with cs_1=1, sclk_1=1, adc_data=0, salida=0, all strobes 0, busy=0, overrun=0, counters 0.

Configuration
REQ-031 Macro ADC_OVERRUN_DETECT_EN defined: overrun sets on any tick dropped per REQ-027 and clears only on Rest.
REQ-032 Macro ADC_OVERRUN_DETECT_EN undefined: overrun SHALL be constant 0 and no detection logic is built.

Structure
REQ-033 Package servo_seq_pkg SHALL hold the FSM state encoding, FRAME_BITS=16, and the default CLK_DIV, SAMPLE_TICKS and DATA_BITS values.
REQ-034 Sub-module adc_spi_rx SHALL contain the sclk_1/cs_1 generator and shift register, with start/done ports; the sequencer FSM and tick counter stay in the top.

Verification (CLK_DIV=2, SAMPLE_TICKS=200, IPD model answers 5 cycles after ipd_start)
REQ-035 ADC frame 0x0ABC, ipd_result 0x4B00 -> cs_1 low 64 cycles, 16 sclk_1 rising edges, adc_data=0xABC, then salida=0x4B00 with one salida_valid pulse.
REQ-036 Frame 0xFFFF -> adc_data=0xFFF; frame 0x0000 -> adc_data=0x000.
REQ-037 IPD model withholds ipd_done for 300 cycles -> one tick dropped; overrun=1 with ADC_OVERRUN_DETECT_EN defined, overrun=0 without it.
REQ-038 Rest pulsed at the 8th sclk_1 rise -> next cycle: cs_1=1, sclk_1=1, busy=0, no strobes; next frame captures cleanly.
REQ-039 enable dropped during CONV -> current cycle completes with salida_valid pulse; no cs_1 activity for the next 400 cycles.
REQ-040 ipd_done asserted in the first COMPUTE cycle only -> ignored; FSM stays in COMPUTE until a later ipd_done.
